mult_host: RTL and testbench
============================

# mult_host

Host-side controller for the 16x16 multiplier block. It sources operand pairs from an upstream valid/ready stream and issues exactly one batch of DEPTH = 2**LOGDEPTH multiplications. It then requests the block read-back and collects the DEPTH results into an indexed result stream with a running checksum. It sits between the test/compute fabric and the multiplier, on the initiator side of the multiplier's EN_mult/RDY_mult and EN_blockRead/VALID_memVal interface.

## Interface
- LOGDEPTH, 6: log2 of the batch size. DEPTH = 2**LOGDEPTH results per batch.
- WIDTH, 32: result width.
- TIMEOUT, 256: watchdog limit in cycles. Used only when MULT_HOST_TIMEOUT_EN is defined.

- clk  in  1  system clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to run one batch; honoured only in IDLE
- op_valid  in  1  upstream operand pair valid
- op_ready  out  1  upstream operand accepted this cycle
- op_a, op_b  in  16 each  operand pair
- EN_mult  out  1  multiply request to the multiplier
- mult_input0, mult_input1  out  16 each  operands to the multiplier
- RDY_mult  in  1  multiplier ready to accept an operand
- EN_blockRead  out  1  block read-back request
- VALID_memVal  in  1  memVal_data carries a valid result this cycle
- memVal_data  in  WIDTH  result from the multiplier
- res_valid  out  1  result beat valid; one cycle per result, no backpressure
- res_data  out  WIDTH  result value
- res_idx  out  LOGDEPTH  result index, 0..DEPTH-1
- checksum  out  WIDTH  sum of batch results modulo 2**WIDTH
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at batch completion
- err  out  1  sticky watchdog/stray-data flag; cleared by rst or by an accepted start

## Operation
- States and transitions:
  - IDLE: start goes to FEED. On the same edge, clear issue_cnt, recv_cnt, checksum and err.
  - FEED: issue operands. After the DEPTH-th acceptance, go to REQ.
  - REQ: EN_blockRead=1. The first VALID_memVal goes to DRAIN, and that beat is captured.
  - DRAIN: capture each VALID_memVal. After the DEPTH-th capture, go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- FEED handshake (combinational):
  - EN_mult = op_valid & (state==FEED).
  - op_ready = EN_mult & RDY_mult.
  - mult_input0 = op_a; mult_input1 = op_b.
  - Acceptance is EN_mult & RDY_mult. Each acceptance increments issue_cnt.
- Capture:
  - Each VALID_memVal in REQ/DRAIN registers res_data = memVal_data and res_idx = recv_cnt[LOGDEPTH-1:0].
  - The same edge sets checksum += memVal_data (wrap modulo 2**WIDTH) and increments recv_cnt.
- Counters: issue_cnt and recv_cnt are LOGDEPTH+1 bits wide, so the count DEPTH is representable without wrap.
- Boundary conditions:
  - start outside IDLE: ignored.
  - op_valid outside FEED: op_ready=0, no acceptance.
  - VALID_memVal in IDLE/FEED/DONE: ignored and sets err.
  - Beats beyond DEPTH: cannot occur, because the block leaves DRAIN on the DEPTH-th beat and the next beat falls in DONE.
  - RDY_mult deasserted mid-FEED: the block stalls. Upstream holds op_a/op_b, and issue_cnt is unchanged.
  - checksum holds its value from DONE until the next accepted start.

## Timing
- Reset values: op_ready=0, EN_mult=0, mult_input0/1 follow op_a/op_b, EN_blockRead=0, res_valid=0, res_data=0, res_idx=0, checksum=0, busy=0, done=0, err=0. State is IDLE.
- Reset mid-operation: return to IDLE on the next edge. No further EN_blockRead.
- start sampled at edge t: busy=1 and FEED in cycle t+1. The first acceptance is possible in t+1.
- Last acceptance at edge t: REQ in t+1, so EN_blockRead is registered and high from t+1.
- EN_blockRead stays high until the edge that samples the first VALID_memVal.
- Capture latency: VALID_memVal at edge t gives res_valid/res_data/res_idx/checksum updated in cycle t+1. res_valid is high one cycle per beat.
- done: high in the same cycle as the final res_valid (res_idx=DEPTH-1), with the final checksum.

## Configuration
- MULT_HOST_TIMEOUT_EN defined: a counter runs in FEED, REQ and DRAIN.
  - It clears on every acceptance or capture.
  - On reaching TIMEOUT: err=1, state goes to IDLE, EN_blockRead drops, done is not pulsed.
- MULT_HOST_TIMEOUT_EN undefined: no counter and no TIMEOUT logic. The block waits indefinitely. err is set only by stray VALID_memVal.

## Test plan
- Nominal batch (LOGDEPTH=6), model multiplier always ready:
  - Stimulus: start, then operands a=i, b=i+1 for i=0..63; model returns the products in order.
  - Required: 64 acceptances, then EN_blockRead; res_idx 0..63 with res_data=i*(i+1); done with checksum=87360 (0x15540); err=0.
- Backpressure: toggle RDY_mult 1/0 every cycle during FEED -> op_ready only when RDY_mult=1; exactly 64 acceptances; operand order preserved.
- Upstream gaps: op_valid low 3 cycles between pairs -> EN_mult low in the gaps; issue_cnt unchanged in the gaps.
- Stray/ignored inputs:
  - VALID_memVal pulsed in FEED -> err=1 sticky; batch still completes.
  - start pulsed mid-DRAIN -> ignored.
- Reset mid-DRAIN after 10 results -> next cycle all outputs at reset values; a new start runs a clean batch with checksum recomputed from 0.
- With MULT_HOST_TIMEOUT_EN, TIMEOUT=256: withhold VALID_memVal in REQ -> err=1 and IDLE exactly 256 cycles after entering REQ; no done pulse.

Source files
------------

// File: rtl/mult_host.sv
// mult_host: host controller that feeds DEPTH operand pairs to the multiplier and collects the indexed results with a checksum.
// Optional watchdog enabled by defining MULT_HOST_TIMEOUT_EN.
module mult_host #(
  parameter int LOGDEPTH = 6,
  parameter int WIDTH = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [15:0]         op_a,
  input  logic [15:0]         op_b,
  output logic                EN_mult,
  output logic [15:0]         mult_input0,
  output logic [15:0]         mult_input1,
  input  logic                RDY_mult,
  output logic                EN_blockRead,
  input  logic                VALID_memVal,
  input  logic [WIDTH-1:0]    memVal_data,
  output logic                res_valid,
  output logic [WIDTH-1:0]    res_data,
  output logic [LOGDEPTH-1:0] res_idx,
  output logic [WIDTH-1:0]    checksum,
  output logic                busy,
  output logic                done,
  output logic                err
);
  localparam logic [2:0] IDLE = 3'd0, FEED = 3'd1, REQ = 3'd2, DRAIN = 3'd3, DONE = 3'd4;
  localparam logic [LOGDEPTH:0] LAST = {1'b0, {LOGDEPTH{1'b1}}};
  logic [2:0] state, nxt;
  logic [LOGDEPTH:0] issue_cnt, recv_cnt;
  logic acc, cap, tmo, go;
  assign EN_mult = op_valid & (state == FEED);
  assign op_ready = EN_mult & RDY_mult;
  assign acc = op_ready;
  assign mult_input0 = op_a;
  assign mult_input1 = op_b;
  assign EN_blockRead = state == REQ;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign cap = VALID_memVal & (state == REQ | state == DRAIN);
  assign go = start & (state == IDLE);
`ifdef MULT_HOST_TIMEOUT_EN
  logic [$clog2(TIMEOUT+1)-1:0] wd_cnt;
  // Idle time since the last acceptance or capture while a batch is in flight.
  always_ff @(posedge clk)
    if (rst || acc || cap || state == IDLE || state == DONE) wd_cnt <= '0;
    else wd_cnt <= wd_cnt + 1'b1;
  assign tmo = busy & ~done & ~acc & ~cap & (wd_cnt == $bits(wd_cnt)'(TIMEOUT - 1));
`else
  assign tmo = 1'b0;
`endif
  always_comb
    nxt = tmo ? IDLE :
          state == IDLE ? (start ? FEED : IDLE) :
          state == FEED ? (acc && issue_cnt == LAST ? REQ : FEED) :
          state == DONE ? IDLE :
          cap ? (recv_cnt == LAST ? DONE : DRAIN) : state;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      issue_cnt <= '0;
      recv_cnt <= '0;
      res_valid <= 1'b0;
      res_data <= '0;
      res_idx <= '0;
      checksum <= '0;
      err <= 1'b0;
    end else begin
      state <= nxt;
      res_valid <= cap;
      err <= (go ? 1'b0 : err) | (VALID_memVal & ~cap) | tmo;
      if (go) begin
        issue_cnt <= '0;
        recv_cnt <= '0;
        checksum <= '0;
      end
      if (acc) issue_cnt <= issue_cnt + 1'b1;
      if (cap) begin
        res_data <= memVal_data;
        res_idx <= recv_cnt[LOGDEPTH-1:0];
        checksum <= checksum + memVal_data;
        recv_cnt <= recv_cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_mult_host.sv
// tb_mult_host: directed bench for mult_host with a behavioural multiplier model.
module tb_mult_host;
  logic clk = 0, rst = 1, start = 0, op_valid = 0, RDY_mult = 0, VALID_memVal = 0;
  logic [15:0] op_a = 0, op_b = 0;
  logic [31:0] memVal_data = 0;
  logic op_ready, EN_mult, EN_blockRead, res_valid, busy, done, err;
  logic [15:0] mult_input0, mult_input1;
  logic [31:0] res_data, checksum;
  logic [5:0] res_idx;
  int n_chk = 0, n_pass = 0;

  mult_host dut (
    .clk(clk), .rst(rst), .start(start), .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .EN_mult(EN_mult), .mult_input0(mult_input0),
    .mult_input1(mult_input1), .RDY_mult(RDY_mult), .EN_blockRead(EN_blockRead),
    .VALID_memVal(VALID_memVal), .memVal_data(memVal_data), .res_valid(res_valid),
    .res_data(res_data), .res_idx(res_idx), .checksum(checksum), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_op_ready"}, op_ready, 0);
    check({tag, "_en_mult"}, EN_mult, 0);
    check({tag, "_en_br"}, EN_blockRead, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_data"}, res_data, 0);
    check({tag, "_res_idx"}, res_idx, 0);
    check({tag, "_checksum"}, checksum, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_in0"}, mult_input0, op_a);
  endtask

  // mode: 0 nominal, 1 RDY toggling, 2 upstream gaps, 3 stray beat + start mid-drain,
  // 4 reset after 10 results, 5 results withheld (watchdog)
  task automatic run_batch(input int mode);
    int sent = 0, caps = 0, got = 0, gap = 0, t0 = -1;
    logic rd = 0, fin = 0, beat = 0, pb = 0, tmo_exp;
    logic [31:0] mq[$];
    logic [31:0] sum = 0;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    #1 check("busy_after_start", busy, 1);
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      op_valid = sent < 64 && gap == 0;
      op_a = 16'(sent);
      op_b = 16'(sent + 1);
      RDY_mult = mode == 1 ? cyc[0] : 1'b1;
      beat = mode != 5 && rd && mq.size() > 0;
      VALID_memVal = beat || (mode == 3 && cyc == 5);
      memVal_data = beat ? mq[0] : 32'hdead;
      start = mode == 3 && caps == 20;
      rst = mode == 4 && got == 10;
      #1;
      tmo_exp = mode == 5 && t0 >= 0 && cyc - t0 >= 256;
      check("en_mult", EN_mult, sent < 64 && op_valid);
      check("op_ready", op_ready, sent < 64 && op_valid && RDY_mult);
      check("en_blockread", EN_blockRead, sent == 64 && caps == 0 && !tmo_exp);
      check("res_valid", res_valid, pb);
      if (EN_blockRead && t0 < 0) t0 = cyc;
      if (op_ready) begin
        check("in0", mult_input0, sent);
        check("in1", mult_input1, sent + 1);
        mq.push_back(32'(op_a) * 32'(op_b));
        sent++;
        gap = mode == 2 ? 3 : 0;
      end else if (gap > 0) gap--;
      if (beat) begin
        void'(mq.pop_front());
        caps++;
      end
      pb = beat;
      if (EN_blockRead) rd = 1;
      if (res_valid) begin
        check("res_idx", res_idx, got);
        check("res_data", res_data, got * (got + 1));
        sum += 32'(got * (got + 1));
        got++;
      end
      if (done) begin
        check("done_count", got, 64);
        check("checksum", checksum, 32'h15540);
        check("checksum_model", checksum, sum);
        check("err_at_done", err, mode == 3);
        fin = 1;
      end
      if (mode == 5 && t0 >= 0 && !busy) begin
        check("tmo_cycles", cyc - t0, 256);
        check("tmo_err", err, 1);
        fin = 1;
      end
      if (rst) begin
        @(negedge clk);
        rst = 0;
        VALID_memVal = 0;
        start = 0;
        op_valid = 1;
        #1 check_reset_outputs("midreset");
        op_valid = 0;
        return;
      end
      @(negedge clk);
    end
    start = 0;
    op_valid = 0;
    VALID_memVal = 0;
    if (!fin) check("batch_finished", fin, 1);
    #1;
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    if (mode != 5) check("checksum_hold", checksum, 32'h15540);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("reset");
    rst = 0;
    run_batch(0);
    run_batch(1);
    run_batch(2);
    run_batch(3);
    run_batch(4);
    run_batch(0);
`ifdef MULT_HOST_TIMEOUT_EN
    run_batch(5);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
